// File: rtl/shift_rgst_rx.sv
// rtl/shift_rgst_rx.sv - LSB-first serial-in/parallel-out frame receiver
// Optional parity check: define SHIFT_RGST_RX_PARITY_CHK_EN.
module shift_rgst_rx #(
  parameter int             w       = 4,
  parameter logic [w-1:0]   rst_val = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sin,
  input  logic                  sin_vld,
  output logic [w-1:0]          q,
  output logic                  done,
  output logic                  busy,
  output logic [$clog2(w):0]    bit_cnt,
  output logic                  err
);

  localparam int CW = $clog2(w) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
`ifdef SHIFT_RGST_RX_PARITY_CHK_EN
  localparam logic [1:0] S_PAR  = 2'd2;
`endif

  logic [1:0]    state_q, state_d;
  logic [w-1:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [w-1:0]  q_q, q_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic [w-1:0]  sr_shift;

  // Incoming bit enters at the MSB so the first bit ends up in bit 0.
  assign sr_shift = {sin, sr_q[w-1:1]};

`ifdef SHIFT_RGST_RX_PARITY_CHK_EN
  logic err_q, err_d;
`endif

  // Next-state logic: frame start/restart, bit collection and completion.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    done_d  = 1'b0;
`ifdef SHIFT_RGST_RX_PARITY_CHK_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RECV;
          sr_d    = '0;
          cnt_d   = '0;
        end
      end
      S_RECV: begin
        if (start) begin
          // Restart drops the partial frame; this cycle's bit is discarded.
          sr_d  = '0;
          cnt_d = '0;
        end else if (sin_vld) begin
          sr_d = sr_shift;
          if (cnt_q == CW'(w - 1)) begin
`ifdef SHIFT_RGST_RX_PARITY_CHK_EN
            cnt_d   = CW'(w);
            state_d = S_PAR;
`else
            q_d     = sr_shift;
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
`ifdef SHIFT_RGST_RX_PARITY_CHK_EN
      S_PAR: begin
        if (start) begin
          sr_d    = '0;
          cnt_d   = '0;
          state_d = S_RECV;
        end else if (sin_vld) begin
          // Even parity: the data ones plus the parity bit must be even.
          q_d     = sr_q;
          done_d  = 1'b1;
          err_d   = (^sr_q) ^ sin;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        sr_d    = '0;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      q_q     <= rst_val;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

`ifdef SHIFT_RGST_RX_PARITY_CHK_EN
  // Parity error flag holds until the next completion or reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign q       = q_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign bit_cnt = cnt_q;

endmodule

// File: tb/tb_shift_rgst_rx.sv
// tb/tb_shift_rgst_rx.sv - self-checking bench for shift_rgst_rx (w=4 and w=8)
module tb_shift_rgst_rx;

`ifdef SHIFT_RGST_RX_PARITY_CHK_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic i_rst[2], i_start[2], i_sin[2], i_vld[2];

  logic [3:0] q4;  logic done4, busy4, err4;  logic [2:0] cnt4;
  logic [7:0] q8;  logic done8, busy8, err8;  logic [3:0] cnt8;

  shift_rgst_rx #(.w(4), .rst_val(4'd5)) u4 (
    .clk(clk), .rst(i_rst[0]), .start(i_start[0]), .sin(i_sin[0]), .sin_vld(i_vld[0]),
    .q(q4), .done(done4), .busy(busy4), .bit_cnt(cnt4), .err(err4));

  shift_rgst_rx #(.w(8), .rst_val(8'd0)) u8 (
    .clk(clk), .rst(i_rst[1]), .start(i_start[1]), .sin(i_sin[1]), .sin_vld(i_vld[1]),
    .q(q8), .done(done8), .busy(busy8), .bit_cnt(cnt8), .err(err8));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a frame is just a list of received bits; word value is sum of bit_k * 2^k.
  int  m_w[2]   = '{4, 8};
  int  m_rv[2]  = '{5, 0};
  bit  m_act[2], m_par[2], m_done[2], m_err[2];
  int  m_q[2];
  int  m_bits[2][$];

  function automatic int bits_val(input int id);
    int v = 0;
    for (int k = 0; k < m_bits[id].size(); k++) v += m_bits[id][k] << k;
    return v;
  endfunction

  function automatic int bits_ones(input int id);
    int n = 0;
    foreach (m_bits[id][k]) n += m_bits[id][k];
    return n;
  endfunction

  task automatic mstep(input int id);
    m_done[id] = 1'b0;
    if (i_rst[id]) begin
      m_act[id] = 0; m_par[id] = 0; m_bits[id].delete(); m_q[id] = m_rv[id]; m_err[id] = 0;
    end else if (i_start[id]) begin
      m_act[id] = 1; m_par[id] = 0; m_bits[id].delete();
    end else if (m_act[id] && i_vld[id]) begin
      if (m_par[id]) begin
        m_q[id] = bits_val(id); m_done[id] = 1;
        m_err[id] = ((bits_ones(id) + int'(i_sin[id])) % 2) == 1;
        m_act[id] = 0;
      end else begin
        m_bits[id].push_back(int'(i_sin[id]));
        if (m_bits[id].size() == m_w[id]) begin
          if (PAR) m_par[id] = 1;
          else begin m_q[id] = bits_val(id); m_done[id] = 1; m_act[id] = 0; end
        end
      end
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare both DUTs.
  task automatic tick();
    @(posedge clk);
    mstep(0); mstep(1);
    #1;
    chk("u4_q",    32'(q4),    32'(m_q[0]));
    chk("u4_done", 32'(done4), 32'(m_done[0]));
    chk("u4_busy", 32'(busy4), 32'(m_act[0]));
    chk("u4_cnt",  32'(cnt4),  m_act[0] ? 32'(m_bits[0].size()) : 32'd0);
    chk("u4_err",  32'(err4),  32'(m_err[0]));
    chk("u8_q",    32'(q8),    32'(m_q[1]));
    chk("u8_done", 32'(done8), 32'(m_done[1]));
    chk("u8_busy", 32'(busy8), 32'(m_act[1]));
    chk("u8_cnt",  32'(cnt8),  m_act[1] ? 32'(m_bits[1].size()) : 32'd0);
    chk("u8_err",  32'(err8),  32'(m_err[1]));
  endtask

  task automatic idle_in(input int id);
    i_rst[id] = 0; i_start[id] = 0; i_vld[id] = 0; i_sin[id] = 0;
  endtask

  // Start a frame and send n bits (bit k = b[k]) with 'gap' invalid cycles before each bit.
  task automatic frame(input int id, input int n, input logic [7:0] b, input int gap);
    idle_in(id); i_start[id] = 1; tick(); i_start[id] = 0;
    for (int k = 0; k < n; k++) begin
      for (int g = 0; g < gap; g++) begin
        i_vld[id] = 0; i_sin[id] = 1'($urandom); tick();
      end
      i_vld[id] = 1; i_sin[id] = b[k]; tick();
    end
    idle_in(id);
  endtask

  task automatic par_bit(input int id, input bit p);
    if (PAR) begin
      i_vld[id] = 1; i_sin[id] = p; tick(); idle_in(id);
    end
  endtask

  typedef struct {
    bit r, s, d, v;
    logic [3:0] q; bit done, busy; logic [2:0] cnt; bit err;
  } vec_t;

  function automatic vec_t mk(bit r, bit s, bit d, bit v, logic [3:0] q, bit dn, bit bz,
                              logic [2:0] c, bit e);
    vec_t t;
    t.r = r; t.s = s; t.d = d; t.v = v; t.q = q; t.done = dn; t.busy = bz; t.cnt = c; t.err = e;
    return t;
  endfunction

  vec_t tbl[9];

  initial begin
    for (int i = 0; i < 2; i++) begin
      idle_in(i); m_q[i] = m_rv[i]; m_act[i] = 0; m_par[i] = 0; m_err[i] = 0; m_done[i] = 0;
    end
    i_rst[1] = 1;

    tbl[0] = mk(1, 0, 0, 0, 4'd5, 0, 0, 3'd0, 0);
    tbl[1] = mk(0, 0, 1, 1, 4'd5, 0, 0, 3'd0, 0);
    tbl[2] = mk(0, 1, 1, 1, 4'd5, 0, 1, 3'd0, 0);
    tbl[3] = mk(0, 0, 1, 1, 4'd5, 0, 1, 3'd1, 0);
    tbl[4] = mk(0, 0, 1, 1, 4'd5, 0, 1, 3'd2, 0);
    tbl[5] = mk(0, 0, 1, 1, 4'd5, 0, 1, 3'd3, 0);
    tbl[6] = PAR ? mk(0, 0, 0, 1, 4'd5, 0, 1, 3'd4, 0) : mk(0, 0, 0, 1, 4'd7, 1, 0, 3'd0, 0);
    tbl[7] = PAR ? mk(0, 0, 0, 1, 4'd7, 1, 0, 3'd0, 1) : mk(0, 0, 0, 1, 4'd7, 0, 0, 3'd0, 0);
    tbl[8] = mk(0, 0, 0, 0, 4'd7, 0, 0, 3'd0, PAR);

    for (int i = 0; i < 9; i++) begin
      i_rst[0] = tbl[i].r; i_start[0] = tbl[i].s; i_sin[0] = tbl[i].d; i_vld[0] = tbl[i].v;
      tick();
      if (i == 0) idle_in(1);
      chk($sformatf("tbl%0d_q", i),    32'(q4),    32'(tbl[i].q));
      chk($sformatf("tbl%0d_done", i), 32'(done4), 32'(tbl[i].done));
      chk($sformatf("tbl%0d_busy", i), 32'(busy4), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_cnt", i),  32'(cnt4),  32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_err", i),  32'(err4),  32'(tbl[i].err));
    end
    idle_in(0);

    // Gaps between bits: 0,0,1,1 -> 1100.
    frame(0, 4, 8'b0000_1100, 2); par_bit(0, 0);
    chk("gap_q", 32'(q4), 32'h0C);
    chk("gap_done", 32'(done4), 32'd1);

    // Restart mid-frame: 1,0 then restart with 0,1,0,1 -> 1010.
    frame(0, 2, 8'b0000_0001, 0);
    frame(0, 4, 8'b0000_1010, 0); par_bit(0, 0);
    chk("restart_q", 32'(q4), 32'h0A);

    // Start on the completion edge wins: no done, frame restarts.
    frame(0, 3, 8'b0000_0111, 0);
    if (PAR) begin i_vld[0] = 1; i_sin[0] = 1; tick(); end
    i_start[0] = 1; i_vld[0] = 1; i_sin[0] = 0; tick(); idle_in(0);
    chk("startwin_done", 32'(done4), 32'd0);
    chk("startwin_cnt", 32'(cnt4), 32'd0);
    chk("startwin_q", 32'(q4), 32'h0A);

    // Reset mid-frame restores rst_val without a done pulse.
    frame(0, 2, 8'b0000_0011, 0);
    i_rst[0] = 1; tick(); idle_in(0);
    chk("midrst_q", 32'(q4), 32'h5);
    chk("midrst_done", 32'(done4), 32'd0);
    frame(0, 4, 8'b0000_1111, 0); par_bit(0, 0);
    chk("ones_q", 32'(q4), 32'hF);

    // Wide instance, sin_vld in IDLE ignored before and after the frame.
    i_vld[1] = 1; i_sin[1] = 1; tick(); tick();
    frame(1, 8, 8'b1111_1100, 0);
    if (!PAR) chk("w8_done_at_9", 32'(done8), 32'd1);
    par_bit(1, 0);
    chk("w8_q", 32'(q8), 32'hFC);
    i_vld[1] = 1; i_sin[1] = 1; tick(); tick(); idle_in(1);
    chk("w8_idle_hold", 32'(q8), 32'hFC);

    if (PAR) begin
      frame(0, 4, 8'b0000_0011, 0); par_bit(0, 0);
      chk("par_ok_q", 32'(q4), 32'h3);
      chk("par_ok_err", 32'(err4), 32'd0);
      frame(0, 4, 8'b0000_0001, 0); par_bit(0, 0);
      chk("par_bad_q", 32'(q4), 32'h1);
      chk("par_bad_err", 32'(err4), 32'd1);
    end

    // Randomized traffic on both instances against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        i_rst[i]   = ($urandom_range(0, 199) == 0);
        i_start[i] = ($urandom_range(0, 14) == 0);
        i_sin[i]   = 1'($urandom);
        i_vld[i]   = ($urandom_range(0, 2) != 0);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
